// File: rtl/jtdsp16_mac.sv
// Pipelined signed multiply-accumulate unit for the DSP16 datapath.
// Operands are registered, multiplied in stage 2, and folded into a guard-bit accumulator in stage 3.
module jtdsp16_mac #(
  parameter  int DW    = 16,
  parameter  int GUARD = 4,
  parameter  int ACCN  = 2,
  localparam int AS    = (ACCN > 1) ? $clog2(ACCN) : 1,
  localparam int AW    = 2*DW + GUARD
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] y_in,
  input  logic          issue,
  input  logic [2:0]    op,
  input  logic [AS-1:0] acc_sel,
  input  logic [1:0]    pshift,
  input  logic          sat_en,
  input  logic [AS-1:0] rd_sel,
  input  logic          ov_clr,
  output logic [DW-1:0] acc_dout,
  output logic [ACCN-1:0] ov,
  output logic [2:0]    flags,
  output logic          busy
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [2:0]    op;
    logic [AS-1:0] sel;
    logic [1:0]    psh;
  } ctl_t;

  logic [STAGES:1]         r_vld_pipe;
  logic [DW-1:0]           r_x, r_y;
  ctl_t                    r_ctl1, r_ctl2;
  logic [2*DW-1:0]         r_p;
  logic [ACCN-1:0][AW-1:0] r_acc;
  logic [ACCN-1:0]         r_ov;
  logic [2:0]              r_flags;

  logic signed [2*DW-1:0]  w_px, w_py, w_prod;
  logic signed [AW-1:0]    w_pext, w_pe;
  logic [AW-1:0]           w_cur, w_res;
  logic                    w_sel_ok, w_wr, w_ovf;
  logic [ACCN-1:0]         w_ov_nxt;
  logic [AW-DW-1:0]        w_top;
  logic                    w_rd_ok, w_sat;

  // Stages 1 and 2: operand capture, then full-width signed product
  assign w_px   = {{DW{r_x[DW-1]}}, r_x};
  assign w_py   = {{DW{r_y[DW-1]}}, r_y};
  assign w_prod = w_px * w_py;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_ctl1     <= '0;
      r_ctl2     <= '0;
      r_p        <= '0;
    end else if (cen) begin
      r_vld_pipe <= {r_vld_pipe[1], issue};
      if (issue) begin
        r_x    <= x_in;
        r_y    <= y_in;
        r_ctl1 <= {op, acc_sel, pshift};
      end
      if (r_vld_pipe[1]) begin
        r_p    <= w_prod;
        r_ctl2 <= r_ctl1;
      end
    end
  end

  // Stage 3: scale product, combine with the live accumulator value
  assign w_pext   = {{GUARD{r_p[2*DW-1]}}, r_p};
  assign w_sel_ok = (32'(r_ctl2.sel) < ACCN);
  assign w_cur    = w_sel_ok ? r_acc[r_ctl2.sel] : '0;

  always_comb begin
    w_pe = w_pext;
    case (r_ctl2.psh)
      2'd0:    w_pe = w_pext;
      2'd2:    w_pe = w_pext <<< 2;
      default: w_pe = w_pext >>> 2;
    endcase
  end

  always_comb begin
    w_res = '0;
    case (r_ctl2.op)
      3'd1:    w_res = w_pe;
      3'd2:    w_res = w_cur + w_pe;
      3'd3:    w_res = w_cur - w_pe;
      3'd5:    w_res = {w_cur[AW-1:DW] + {{(AW-DW-1){1'b0}}, w_cur[DW-1]}, {DW{1'b0}}};
      default: w_res = '0;
    endcase
  end

  assign w_wr  = r_vld_pipe[2] && w_sel_ok && (r_ctl2.op != 3'd0) && (r_ctl2.op <= 3'd5);
  assign w_ovf = !(&w_res[AW-1:2*DW-1]) && (|w_res[AW-1:2*DW-1]);

  // A fresh overflow beats both the global clear and the op=4 clear
  always_comb begin
    w_ov_nxt = ov_clr ? '0 : r_ov;
    if (w_wr) begin
      if (r_ctl2.op == 3'd4) w_ov_nxt[r_ctl2.sel] = 1'b0;
      if (w_ovf)             w_ov_nxt[r_ctl2.sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_ov    <= '0;
      r_flags <= '0;
    end else if (cen) begin
      r_ov <= w_ov_nxt;
      if (w_wr) begin
        r_acc[r_ctl2.sel] <= w_res;
        r_flags           <= {w_res[AW-1], (w_res == '0), w_ovf};
      end
    end
  end

  // Readout: high product word, clamped when guard bits disagree with the sign
  assign w_rd_ok = (32'(rd_sel) < ACCN);
  assign w_top   = w_rd_ok ? r_acc[rd_sel][AW-1:DW] : '0;
  assign w_sat   = sat_en && !(&w_top[AW-DW-1:DW-1]) && (|w_top[AW-DW-1:DW-1]);

  always_comb begin
    acc_dout = w_top[DW-1:0];
    if (w_sat) acc_dout = w_top[AW-DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  assign ov    = r_ov;
  assign flags = r_flags;
  assign busy  = |r_vld_pipe;

endmodule

// File: tb/tb_jtdsp16_mac.sv
// Randomised bench for jtdsp16_mac against a queue-based arithmetic model of the accumulators.
module tb_jtdsp16_mac;

  logic        clk = 1'b0;
  logic        rst_n, cen, issue, sat_en, ov_clr;
  logic [15:0] x_in, y_in;
  logic [2:0]  op;
  logic [0:0]  acc_sel, rd_sel;
  logic [1:0]  pshift;
  logic [15:0] acc_dout;
  logic [1:0]  ov;
  logic [2:0]  flags;
  logic        busy;

  jtdsp16_mac dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .x_in(x_in), .y_in(y_in), .issue(issue),
    .op(op), .acc_sel(acc_sel), .pshift(pshift), .sat_en(sat_en), .rd_sel(rd_sel),
    .ov_clr(ov_clr), .acc_dout(acc_dout), .ov(ov), .flags(flags), .busy(busy)
  );

  always #10 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: accumulators held as signed integers in [-2^35, 2^35)
  typedef struct {
    int          idx;
    logic [15:0] x, y;
    int          op, sel, psh;
  } pend_t;

  localparam longint TWO35 = 64'sd1 << 35;
  localparam longint TWO31 = 64'sd1 << 31;

  pend_t  q[$];
  longint m_acc[2];
  logic [1:0] m_ov;
  logic [2:0] m_flags;
  int     ecnt;

  function automatic longint wrap(input longint v);
    longint r;
    r = v % (2*TWO35);
    if (r < 0) r += 2*TWO35;
    if (r >= TWO35) r -= 2*TWO35;
    return r;
  endfunction

  task automatic m_reset();
    q.delete();
    m_acc[0] = 0; m_acc[1] = 0;
    m_ov = '0; m_flags = '0; ecnt = 0;
  endtask

  task automatic m_apply(input pend_t e);
    longint prod, sc, res;
    prod = longint'($signed(e.x)) * longint'($signed(e.y));
    if (e.psh == 0)      sc = prod;
    else if (e.psh == 2) sc = prod * 4;
    else                 sc = prod >>> 2;
    case (e.op)
      1: res = wrap(sc);
      2: res = wrap(m_acc[e.sel] + sc);
      3: res = wrap(m_acc[e.sel] - sc);
      4: res = 0;
      5: res = wrap(((m_acc[e.sel] + 32768) >>> 16) * 65536);
      default: return;
    endcase
    m_acc[e.sel] = res;
    if (e.op == 4) m_ov[e.sel] = 1'b0;
    if (res >= TWO31 || res < -TWO31) m_ov[e.sel] = 1'b1;
    m_flags = {res < 0, res == 0, (res >= TWO31 || res < -TWO31)};
  endtask

  // Called right after a posedge with cen high; inputs are still the sampled ones
  task automatic m_edge();
    pend_t e;
    if (ov_clr) m_ov = '0;
    while (q.size() > 0 && q[0].idx == ecnt - 2) begin
      e = q.pop_front();
      m_apply(e);
    end
    if (issue) begin
      e.idx = ecnt; e.x = x_in; e.y = y_in; e.op = int'(op); e.sel = int'(acc_sel); e.psh = int'(pshift);
      q.push_back(e);
    end
    ecnt++;
  endtask

  function automatic logic [15:0] exp_dout(input int sel, input bit sat);
    longint a;
    logic [35:0] bits;
    a = m_acc[sel];
    bits = a[35:0];
    if (sat && a >= TWO31)  return 16'h7FFF;
    if (sat && a < -TWO31)  return 16'h8000;
    return bits[31:16];
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 2; s++) begin
        rd_sel = i[0:0]; sat_en = s[0]; #1;
        chk($sformatf("%s dout%0d s%0d", tag, i, s), acc_dout, exp_dout(i, s[0]));
      end
    end
    chk({tag, " ov"}, ov, m_ov);
    chk({tag, " flags"}, flags, m_flags);
    chk({tag, " busy"}, busy, q.size() > 0);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (cen && rst_n) m_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic drive(input bit iss, input logic [15:0] x, y, input int o, s, p);
    issue = iss; x_in = x; y_in = y; op = o[2:0]; acc_sel = s[0:0]; pshift = p[1:0];
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b1; ov_clr = 1'b0; sat_en = 1'b0; rd_sel = '0;
    drive(0, 0, 0, 0, 0, 0);
    m_reset();
    #25;
    chk("rst dout", acc_dout, 16'h0);
    chk("rst ov", ov, 2'b00);
    chk("rst flags", flags, 3'b000);
    chk("rst busy", busy, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // 0x4000*0x4000 into acc0
    drive(1, 16'h4000, 16'h4000, 1, 0, 0); tick("basic");
    drive(0, 0, 0, 0, 0, 0);
    tick("basic"); tick("basic");
    rd_sel = 0; sat_en = 0; #1;
    chk("basic dout", acc_dout, 16'h1000);
    chk("basic busy", busy, 1'b0);

    // Accumulate 0x7FFF^2 ten times into acc1
    for (int i = 0; i < 10; i++) begin drive(1, 16'h7FFF, 16'h7FFF, 2, 1, 0); tick("ovf"); end
    drive(0, 0, 0, 0, 0, 0);
    tick("ovf"); tick("ovf");
    rd_sel = 1; sat_en = 1; #1;
    chk("ovf sat", acc_dout, 16'h7FFF);
    chk("ovf bit", ov[1], 1'b1);
    chk("ovf lmv", flags[0], 1'b1);

    // Product scaling: arithmetic right and left shift
    drive(1, 16'h8000, 16'h7FFF, 1, 0, 1); tick("psh");
    drive(1, 16'h8000, 16'h7FFF, 1, 1, 2); tick("psh");
    drive(1, 16'h8000, 16'h7FFF, 1, 0, 3); tick("psh");
    drive(0, 0, 0, 0, 0, 0);
    tick("psh"); tick("psh");

    // Round: 0x0_1234_8000 -> 0x0_1235_0000
    drive(1, 16'h1000, 16'h48D2, 1, 0, 2); tick("rnd");
    drive(1, 0, 0, 5, 0, 0); tick("rnd");
    drive(0, 0, 0, 0, 0, 0);
    tick("rnd"); tick("rnd");
    rd_sel = 0; sat_en = 0; #1;
    chk("rnd dout", acc_dout, 16'h1235);

    // ov_clr lands on the same edge as a fresh overflow on acc1
    drive(1, 16'h7FFF, 16'h7FFF, 2, 1, 0); tick("ovclr");
    drive(0, 0, 0, 0, 0, 0); tick("ovclr");
    ov_clr = 1'b1; tick("ovclr");
    ov_clr = 1'b0;
    chk("ovclr set wins", ov[1], 1'b1);
    ov_clr = 1'b1; tick("ovclr2"); ov_clr = 1'b0;
    drive(1, 0, 0, 4, 1, 0); tick("clr4");
    drive(0, 0, 0, 0, 0, 0); tick("clr4"); tick("clr4");

    // Randomised interleave with cen toggling
    for (int n = 0; n < 400; n++) begin
      cen = $urandom_range(0, 1) == 1;
      ov_clr = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 9) == 0)
        drive($urandom_range(0, 4) != 0, 16'($urandom), 16'($urandom),
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3));
      else
        drive($urandom_range(0, 4) != 0, 16'($urandom), 16'($urandom),
              (n % 2 == 0) ? 2 : 3, n % 2, $urandom_range(0, 3));
      tick("rand");
    end
    cen = 1'b1; ov_clr = 1'b0;

    // Reset with both pipeline stages occupied
    drive(1, 16'h7FFF, 16'h7FFF, 1, 0, 0); tick("midrst");
    drive(1, 16'h1234, 16'h5678, 1, 1, 0); tick("midrst");
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0; m_reset(); #1;
    check_all("midrst low");
    @(negedge clk); rst_n = 1'b1;
    tick("midrst post"); tick("midrst post"); tick("midrst post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
